link_rx_inject_buffer: RTL
==========================

Name: link_rx_inject_buffer

Overview:
- Receive-side end of an inter-node link.
- Takes parallel packets recovered by the link receiver and buffers them in a FIFO.
- Presents buffered packets to the switch's per-direction inject port using the inject/inject_receive/InjectSlotAvail handshake.
- Returns flow-control credits to the remote transmitter, and gates acceptance with a link-training state machine plus a sticky overflow error.

Parameters:
- DataWidth, 256, packet width; bit DataWidth-1 is the valid flag.
- FIFODepth, 8, buffered packets; power of 2, minimum 2.
- AddrWidth, 3, log2(FIFODepth).
- CreditBatch, 2, dequeues per credit_return pulse; range 1..FIFODepth.
- TrainCycles, 4, consecutive idle link words required before link-up; range 1..255.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  reset; asynchronous, active-high.
- rx_par_data  in  DataWidth  packet from link receiver; valid when bit DataWidth-1 is 1.
- rx_ready  out  1  link up and buffer accepting; drives the link's rx_ready.
- inject  out  DataWidth  packet presented to the switch; valid bit forced 1 when inject_receive=1.
- inject_receive  out  1  inject is valid this cycle and is consumed this cycle.
- InjectSlotAvail  in  1  switch input slot free this cycle.
- credit_return  out  1  one-cycle pulse; one credit equals CreditBatch freed slots.
- fifo_count  out  AddrWidth+1  current occupancy.
- link_up  out  1  state == UP.
- overflow_err  out  1  sticky; set on an overflow drop.

Behaviour:
- Reset (async assert, sync use after deassert): state=TRAIN, train counter=0, FIFO empty (read/write pointers 0, count 0), pending credit counter=0.
  - Outputs at reset: rx_ready=0, inject_receive=0, inject=0, credit_return=0, fifo_count=0, link_up=0, overflow_err=0.
- States:
  - TRAIN:
    - Each cycle with valid=0 increments the train counter; valid=1 clears it to 0 and drops the word.
    - When the counter reaches TrainCycles-1 on an idle cycle, go to UP on the next edge.
    - rx_ready=0.
  - UP:
    - rx_ready = (count < FIFODepth) OR pop-this-cycle, combinational.
    - Word with valid=1 is pushed.
    - Push when count==FIFODepth with no simultaneous pop → go to ERR, drop the word, set overflow_err.
  - ERR:
    - rx_ready=0; all incoming words are dropped.
    - FIFO keeps draining to the switch; credits keep returning.
    - Exit only via rst.
- FIFO is show-ahead. A word pushed at edge N is visible on inject and eligible for inject_receive in cycle N+1, so minimum latency is 1 cycle. There is no same-cycle bypass.
- Pop: inject_receive = (count>0) AND InjectSlotAvail, combinational.
  - inject = head entry when count>0, else 0.
  - The pop commits at the same edge.
- Simultaneous push and pop: count is unchanged and both pointers advance. This is legal when full (the full+pop push is accepted) and when empty (pop is impossible, so count goes to 1).
- Pointers wrap modulo FIFODepth. fifo_count is the registered occupancy, range 0..FIFODepth.
- Credits:
  - Each pop increments the pending counter.
  - When pending+pop reaches CreditBatch, credit_return=1 on the next cycle and pending becomes pending+pop-CreditBatch.
  - At most one pulse per cycle; no credit is ever lost.
  - Pulses continue in ERR.
- Words arriving with valid=0 are never stored in any state.
- rst asserted mid-operation: immediately returns to the reset values above. Buffered packets and pending credits are discarded.

Test Plan:
- Training: 3 idle words, 1 valid word, then 4 idle words → link_up rises exactly 4 cycles after the last valid word; the valid word is dropped; fifo_count stays 0.
- Pass-through: UP, InjectSlotAvail=1, push A (bit255=1, payload 0xAA) at edge N → inject_receive=1 in cycle N+1 with inject=A; fifo_count back to 0 after edge N+1.
- Back-pressure/full: InjectSlotAvail=0, push 8 packets → fifo_count=8, rx_ready=0. Raise InjectSlotAvail → packets exit in order 1..8 on consecutive cycles; rx_ready=1 from the first pop.
- Full with simultaneous push+pop: count=8, InjectSlotAvail=1, push P9 → count stays 8, overflow_err=0; P9 exits after P8.
- Overflow: count=8, InjectSlotAvail=0, force a push → overflow_err=1, state ERR, rx_ready=0, word dropped. Then 8 pops → 4 credit_return pulses; rx_ready stays 0.
- Credits and reset: 5 pops → 2 credit_return pulses with pending=1. Assert rst mid-stream → all outputs 0 asynchronously; pending count lost; TRAIN re-entered.

Source files
------------

// File: rtl/link_rx_inject_buffer.sv
// link_rx_inject_buffer
//   Receive-side end of an inter-node link. Packets recovered by the link
//   receiver are buffered in a show-ahead FIFO and offered to the switch's
//   inject port. Freed slots are returned to the remote transmitter as
//   batched credits. A link-training FSM gates acceptance, and an overflow
//   latches a sticky error state that only reset clears.
//
// Handshakes:
//   inject/InjectSlotAvail: the FIFO head is offered on inject whenever the
//   FIFO holds a packet. When InjectSlotAvail is high in that cycle,
//   inject_receive goes high and the packet is consumed at the next clock
//   edge. No state is kept from one offer to the next.
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   rx_par_data      packet from the link receiver (MSB = valid flag)
//   rx_ready         link up and buffer accepting
//   inject           packet offered to the switch (0 when the FIFO is empty)
//   inject_receive   inject is valid and is consumed this cycle
//   InjectSlotAvail  switch input slot free this cycle
//   credit_return    one-cycle pulse per CreditBatch freed slots
//   fifo_count       registered occupancy, 0..FIFODepth
//   link_up          FSM is in UP
//   overflow_err     sticky overflow-drop flag
//   dbg_state        current FSM state, for debug observation
module link_rx_inject_buffer #(
  parameter int DataWidth   = 256,
  parameter int FIFODepth   = 8,
  parameter int AddrWidth   = 3,
  parameter int CreditBatch = 2,
  parameter int TrainCycles = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DataWidth-1:0] rx_par_data,
  output logic                 rx_ready,
  output logic [DataWidth-1:0] inject,
  output logic                 inject_receive,
  input  logic                 InjectSlotAvail,
  output logic                 credit_return,
  output logic [AddrWidth:0]   fifo_count,
  output logic                 link_up,
  output logic                 overflow_err,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    ST_TRAIN = 2'd0,
    ST_UP    = 2'd1,
    ST_ERR   = 2'd2
  } state_e;

  localparam logic [AddrWidth:0] DEPTH_C    = (AddrWidth+1)'(FIFODepth);
  localparam logic [AddrWidth:0] BATCH_C    = (AddrWidth+1)'(CreditBatch);
  localparam logic [7:0]         TRAIN_LAST = 8'(TrainCycles - 1);

  state_e                 state_q, state_d;
  logic [7:0]             train_q, train_d;
  logic                   ovf_q, ovf_d;
  logic [AddrWidth-1:0]   wr_q, rd_q;
  logic [AddrWidth:0]     count_q, count_d;
  logic [AddrWidth:0]     pend_q, pend_d, pend_sum;
  logic                   credit_q, credit_d;
  logic [DataWidth-1:0]   mem_q [FIFODepth];

  logic word_valid;
  logic fifo_full;
  logic fifo_nonempty;
  logic push;
  logic pop;

  assign word_valid    = rx_par_data[DataWidth-1];
  assign fifo_full     = (count_q == DEPTH_C);
  assign fifo_nonempty = (count_q != '0);
  assign pop           = fifo_nonempty && InjectSlotAvail;

  // FSM next state, acceptance and push decision.
  always_comb begin
    state_d  = state_q;
    train_d  = train_q;
    ovf_d    = ovf_q;
    push     = 1'b0;
    rx_ready = 1'b0;
    unique case (state_q)
      ST_TRAIN: begin
        if (word_valid) begin
          // Any valid word during training restarts the idle run; the word is dropped.
          train_d = '0;
        end else if (train_q == TRAIN_LAST) begin
          state_d = ST_UP;
          train_d = '0;
        end else begin
          train_d = train_q + 8'd1;
        end
      end
      ST_UP: begin
        // A pop in the same cycle frees a slot, so a full FIFO still accepts.
        rx_ready = !fifo_full || pop;
        if (word_valid) begin
          if (fifo_full && !pop) begin
            state_d = ST_ERR;
            ovf_d   = 1'b1;
          end else begin
            push = 1'b1;
          end
        end
      end
      ST_ERR: begin
        // Incoming words are dropped; the FIFO keeps draining.
      end
      default: state_d = ST_TRAIN;
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pending frees below one batch are carried so no credit is ever lost.
  always_comb begin
    pend_sum = pend_q + {{AddrWidth{1'b0}}, pop};
    credit_d = (pend_sum >= BATCH_C);
    pend_d   = credit_d ? (pend_sum - BATCH_C) : pend_sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_TRAIN;
      train_q  <= '0;
      ovf_q    <= 1'b0;
      wr_q     <= '0;
      rd_q     <= '0;
      count_q  <= '0;
      pend_q   <= '0;
      credit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      train_q  <= train_d;
      ovf_q    <= ovf_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      credit_q <= credit_d;
      // Depth is a power of two, so pointers wrap naturally.
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read when count says they are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= rx_par_data;
  end

  always_comb begin
    inject = '0;
    if (fifo_nonempty) begin
      inject = mem_q[rd_q];
      if (pop) inject[DataWidth-1] = 1'b1;
    end
  end

  assign inject_receive = pop;
  assign credit_return  = credit_q;
  assign fifo_count     = count_q;
  assign link_up        = (state_q == ST_UP);
  assign overflow_err   = ovf_q;
  assign dbg_state      = state_q;

endmodule
